// File: rtl/rle_video_if.sv
// Pixel-in / RLE-word-out handshake bundle for rle_video_encoder.
// slave = encoder side, master = pixel source and word sink.
interface rle_video_if;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned WORD_W = 16;

    logic              pix_valid;
    logic              pix_ready;
    logic [COL_W-1:0]  pix_colour;
    logic              pix_eol;
    logic              pix_eof;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;

    modport slave (
        input  pix_valid, pix_colour, pix_eol, pix_eof, word_ready,
        output pix_ready, word_valid, word_data
    );

    modport master (
        output pix_valid, pix_colour, pix_eol, pix_eof, word_ready,
        input  pix_ready, word_valid, word_data
    );
endinterface

// File: rtl/rle_video_encoder.sv
// Streaming 6-bit pixel run-length encoder producing 16-bit {run,colour} words.
// Optional feature macro RLE_AUDIO_EN: one audio word emitted after each row's last run.
module rle_video_encoder #(
    parameter int unsigned MAX_RUN    = 1023,
    parameter int unsigned COUNT_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    rle_video_if.slave            bus,
    output logic [COUNT_BITS-1:0] word_count
`ifdef RLE_AUDIO_EN
    ,
    input  logic [7:0]            audio_sample
`endif
);
    localparam int unsigned RUN_W  = 10;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH_RUN = 2'd1,
        ST_FLUSH_EOF = 2'd2
`ifdef RLE_AUDIO_EN
        ,
        ST_FLUSH_AUDIO = 2'd3
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    state_t              row_end_state;
    logic [COL_W-1:0]    run_col;
    logic [RUN_W-1:0]    run_len;
    logic                run_act;
    logic                eof_q;
    logic [COL_W-1:0]    run_col_nxt;
    logic [RUN_W-1:0]    run_len_nxt;
    logic                run_act_nxt;
    logic                load;
    logic [WORD_W-1:0]   load_data;
    logic                out_free;
    logic                accept;
    logic                eol_eff;
    logic                same_run;
    logic                closes;
`ifdef RLE_AUDIO_EN
    logic [7:0]          audio_q;
`endif

    assign out_free      = !bus.word_valid || bus.word_ready;
    assign bus.pix_ready = out_free && (state == ST_RUN);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign eol_eff       = bus.pix_eol || bus.pix_eof;
    assign same_run      = run_act && (bus.pix_colour == run_col) && (run_len < RUN_W'(MAX_RUN));
    assign closes        = run_act && !same_run;

    // Where a finished row goes once its last run word is out.
`ifdef RLE_AUDIO_EN
    assign row_end_state = ST_FLUSH_AUDIO;
`else
    logic eof_sel;
    assign eof_sel       = (state == ST_RUN) ? bus.pix_eof : eof_q;
    assign row_end_state = eof_sel ? ST_FLUSH_EOF : ST_RUN;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (accept && eol_eff) state_nxt = closes ? ST_FLUSH_RUN : row_end_state;
            end
            ST_FLUSH_RUN: begin
                if (out_free) state_nxt = row_end_state;
            end
`ifdef RLE_AUDIO_EN
            ST_FLUSH_AUDIO: begin
                if (out_free) state_nxt = eof_q ? ST_FLUSH_EOF : ST_RUN;
            end
`endif
            ST_FLUSH_EOF: begin
                if (out_free) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Run-register update and output-word selection.
    always_comb begin
        load        = 1'b0;
        load_data   = '0;
        run_col_nxt = run_col;
        run_len_nxt = run_len;
        run_act_nxt = run_act;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (same_run) begin
                        run_len_nxt = run_len + RUN_W'(1);
                    end else begin
                        if (closes) begin
                            load      = 1'b1;
                            load_data = {run_len, run_col};
                        end
                        run_col_nxt = bus.pix_colour;
                        run_len_nxt = RUN_W'(1);
                    end
                    run_act_nxt = 1'b1;
                    if (eol_eff) begin
                        run_act_nxt = 1'b0;
                        // A closed old run takes this cycle; the 1-pixel run waits in FLUSH_RUN.
                        if (!closes) begin
                            load      = 1'b1;
                            load_data = {run_len_nxt, run_col_nxt};
                        end
                    end
                end
            end
            ST_FLUSH_RUN: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = {run_len, run_col};
                end
            end
`ifdef RLE_AUDIO_EN
            ST_FLUSH_AUDIO: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = {8'h00, audio_q};
                end
            end
`endif
            ST_FLUSH_EOF: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.word_valid <= 1'b0;
            bus.word_data  <= '0;
            word_count     <= '0;
            run_col        <= '0;
            run_len        <= '0;
            run_act        <= 1'b0;
            eof_q          <= 1'b0;
`ifdef RLE_AUDIO_EN
            audio_q        <= '0;
`endif
        end else begin
            run_col <= run_col_nxt;
            run_len <= run_len_nxt;
            run_act <= run_act_nxt;
            if (load) begin
                bus.word_valid <= 1'b1;
                bus.word_data  <= load_data;
            end else if (bus.word_ready) begin
                bus.word_valid <= 1'b0;
            end
            if (bus.word_valid && bus.word_ready) word_count <= word_count + COUNT_BITS'(1);
            if (accept && eol_eff) begin
                eof_q <= bus.pix_eof;
`ifdef RLE_AUDIO_EN
                audio_q <= audio_sample;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rle_video_encoder.sv
// Self-checking bench for rle_video_encoder: directed cases plus random frames
// compared against a row/run-splitting reference model.
module tb_rle_video_encoder;
    localparam int unsigned MAX_RUN    = 1023;
    localparam int unsigned COUNT_BITS = 24;

    typedef struct packed {
        logic [5:0] col;
        logic       eol;
        logic       eof;
        logic [7:0] aud;
    } pix_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [COUNT_BITS-1:0] word_count;
`ifdef RLE_AUDIO_EN
    logic [7:0]            audio_sample = 8'h00;
`endif

    rle_video_if ifc();

    rle_video_encoder #(.MAX_RUN(MAX_RUN), .COUNT_BITS(COUNT_BITS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc),
        .word_count(word_count)
`ifdef RLE_AUDIO_EN
        ,
        .audio_sample(audio_sample)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
    int          exp_total = 0;
    bit          drv_timeout = 1'b0;
    pix_t        stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    // Word sink: drives word_ready at negedge, records handshakes just before posedge.
    always begin
        @(negedge clk);
        case (ready_mode)
            0:       ifc.word_ready = 1'b1;
            1:       ifc.word_ready = 1'($urandom_range(1));
            default: ifc.word_ready = 1'b0;
        endcase
        #4;
        if (ifc.word_valid === 1'b1 && ifc.word_ready === 1'b1) got_q.push_back(ifc.word_data);
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void push_px(input logic [5:0] col, input logic eol, input logic eof,
                                    input logic [7:0] aud);
        pix_t p;
        p.col = col; p.eol = eol; p.eof = eof; p.aud = aud;
        stim_q.push_back(p);
    endfunction

    // Reference: split each row into maximal same-colour groups, chunk each by MAX_RUN.
    function automatic void build_exp();
        int i = 0;
        exp_q.delete();
        while (i < stim_q.size()) begin
            int j = i;
            int k;
            while (j < stim_q.size() - 1 && !(stim_q[j].eol || stim_q[j].eof)) j++;
            k = i;
            while (k <= j) begin
                logic [5:0] c = stim_q[k].col;
                int len = 0;
                while (k <= j && stim_q[k].col == c) begin len++; k++; end
                while (len > int'(MAX_RUN)) begin
                    exp_q.push_back({10'(MAX_RUN), c});
                    len -= int'(MAX_RUN);
                end
                exp_q.push_back({10'(len), c});
            end
`ifdef RLE_AUDIO_EN
            exp_q.push_back({8'h00, stim_q[j].aud});
`endif
            if (stim_q[j].eof) exp_q.push_back(16'h0000);
            i = j + 1;
        end
    endfunction

    task automatic drive_pixels(input int gap);
        drv_timeout = 1'b0;
        foreach (stim_q[i]) begin
            int tmo;
            @(negedge clk);
            while (gap > 0 && $urandom_range(99) < gap) begin
                ifc.pix_valid  = 1'b0;
                ifc.pix_colour = 6'($urandom);
                @(negedge clk);
            end
            ifc.pix_valid  = 1'b1;
            ifc.pix_colour = stim_q[i].col;
            ifc.pix_eol    = stim_q[i].eol;
            ifc.pix_eof    = stim_q[i].eof;
`ifdef RLE_AUDIO_EN
            audio_sample   = stim_q[i].aud;
`endif
            tmo = 0;
            #4;
            while (ifc.pix_ready !== 1'b1 && tmo < 3000) begin
                @(negedge clk);
                #4;
                tmo++;
            end
            if (tmo >= 3000) drv_timeout = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        ifc.pix_valid = 1'b0;
        ifc.pix_eol   = 1'b0;
        ifc.pix_eof   = 1'b0;
    endtask

    task automatic wait_words();
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) drv_timeout = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        exp_total += exp_q.size();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ifc.pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_total = 0;
    endtask

    task automatic test_reset();
        ready_mode = 0;
        ifc.pix_valid = 1'b0; ifc.pix_eol = 1'b0; ifc.pix_eof = 1'b0; ifc.pix_colour = 6'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifc.word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid got=%b exp=0", ifc.word_valid); end
        checks++;
        if (word_count !== '0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        checks++;
        if (ifc.word_data !== 16'h0000) begin failures++; $display("FAIL reset_word_data got=%h exp=0000", ifc.word_data); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #4;
        checks++;
        if (ifc.pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%b exp=1", ifc.pix_ready); end
        got_q.delete();
        exp_total = 0;
    endtask

    task automatic test_basic_runs();
        stim_q.delete();
        for (int i = 0; i < 5; i++) push_px(6'h3F, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) push_px(6'h01, i == 2, 1'b0, 8'h00);
        exp_q = '{16'h017F, 16'h00C1};
`ifdef RLE_AUDIO_EN
        exp_q.push_back(16'h0000);
`endif
        got_q.delete();
        drive_pixels(0);
        wait_words();
        checks++;
        if (drv_timeout || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_count got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), drv_timeout);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_max_run();
        logic [COUNT_BITS-1:0] cnt0 = word_count;
        stim_q.delete();
        for (int i = 0; i < 1025; i++) push_px(6'h12, i == 1024, 1'b0, 8'h00);
        exp_q = '{16'hFFD2, 16'h0092};
`ifdef RLE_AUDIO_EN
        exp_q.push_back(16'h0000);
`endif
        got_q.delete();
        drive_pixels(0);
        wait_words();
        checks++;
        if (drv_timeout || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL maxrun_count got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), drv_timeout);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL maxrun_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
        checks++;
        if (word_count !== cnt0 + COUNT_BITS'(exp_q.size())) begin
            failures++; $display("FAIL maxrun_word_count got=%0d exp=%0d", word_count, cnt0 + COUNT_BITS'(exp_q.size()));
        end
    endtask

    task automatic test_eof();
        stim_q.delete();
        push_px(6'h05, 1'b0, 1'b0, 8'h00);
        push_px(6'h05, 1'b0, 1'b0, 8'h00);
        push_px(6'h2A, 1'b1, 1'b1, 8'h00);
        exp_q.delete();
        exp_q.push_back(16'h0085);
        exp_q.push_back(16'h006A);
`ifdef RLE_AUDIO_EN
        exp_q.push_back(16'h0000);
`endif
        exp_q.push_back(16'h0000);
        got_q.delete();
        drive_pixels(0);
        wait_words();
        checks++;
        if (drv_timeout || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL eof_count got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), drv_timeout);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL eof_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        stim_q.delete();
        push_px(6'h3F, 1'b0, 1'b0, 8'h00);
        push_px(6'h3F, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) push_px(6'h01, i == 2, 1'b0, 8'h00);
        exp_q = '{16'h00BF, 16'h00C1};
`ifdef RLE_AUDIO_EN
        exp_q.push_back(16'h0000);
`endif
        got_q.delete();
        ready_mode = 2;
        fork
            drive_pixels(0);
        join_none
        while (ifc.word_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #4;
            checks++;
            if (ifc.word_valid !== 1'b1 || ifc.word_data !== 16'h00BF || ifc.pix_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d got valid=%b data=%h ready=%b exp valid=1 data=00bf ready=0",
                         c, ifc.word_valid, ifc.word_data, ifc.pix_ready);
            end
        end
        ready_mode = 0;
        wait_words();
        wait fork;
        checks++;
        if (drv_timeout || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL stall_count got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), drv_timeout);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL stall_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
        checks++;
        if (word_count !== COUNT_BITS'(exp_total)) begin
            failures++; $display("FAIL stall_word_count got=%0d exp=%0d", word_count, exp_total);
        end
    endtask

    task automatic test_reset_midrun();
        stim_q.delete();
        push_px(6'h0A, 1'b0, 1'b0, 8'h00);
        push_px(6'h0A, 1'b0, 1'b0, 8'h00);
        push_px(6'h0B, 1'b0, 1'b0, 8'h00);
        ready_mode = 2;
        drive_pixels(0);
        apply_reset();
        #4;
        checks++;
        if (ifc.word_valid !== 1'b0 || word_count !== '0) begin
            failures++; $display("FAIL midrst_state got valid=%b count=%0d exp valid=0 count=0", ifc.word_valid, word_count);
        end
        ready_mode = 0;
        stim_q.delete();
        push_px(6'h07, 1'b0, 1'b0, 8'h00);
        push_px(6'h07, 1'b1, 1'b1, 8'h00);
        exp_q.delete();
        exp_q.push_back(16'h0087);
`ifdef RLE_AUDIO_EN
        exp_q.push_back(16'h0000);
`endif
        exp_q.push_back(16'h0000);
        got_q.delete();
        drive_pixels(0);
        wait_words();
        checks++;
        if (drv_timeout || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL midrst_count got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), drv_timeout);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL midrst_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
        checks++;
        if (word_count !== COUNT_BITS'(exp_total)) begin
            failures++; $display("FAIL midrst_word_count got=%0d exp=%0d", word_count, exp_total);
        end
    endtask

    function automatic void gen_frame();
        logic [5:0] pal [3];
        int rows = $urandom_range(4, 1);
        stim_q.delete();
        for (int p = 0; p < 3; p++) pal[p] = 6'($urandom);
        for (int r = 0; r < rows; r++) begin
            int len = $urandom_range(40, 1);
            for (int p = 0; p < len; p++) begin
                logic last = (p == len - 1);
                logic eofp = last && (r == rows - 1);
                logic eolp = last && !(eofp && $urandom_range(1) == 0);
                push_px(pal[$urandom_range(2)], eolp, eofp, 8'($urandom));
            end
        end
    endfunction

    task automatic run_random(input string tag, input int frames, input int gap, input int mode);
        ready_mode = mode;
        for (int f = 0; f < frames; f++) begin
            gen_frame();
            build_exp();
            got_q.delete();
            drive_pixels(gap);
            wait_words();
            checks++;
            if (drv_timeout || got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL %s_f%0d_count got=%0d exp=%0d timeout=%0b", tag, f, got_q.size(), exp_q.size(), drv_timeout);
            end
            foreach (exp_q[i]) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL %s_f%0d_word%0d got=%h exp=%h", tag, f, i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
                end
            end
            checks++;
            if (word_count !== COUNT_BITS'(exp_total)) begin
                failures++; $display("FAIL %s_f%0d_word_count got=%0d exp=%0d", tag, f, word_count, exp_total);
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_back_to_back();
        run_random("b2b", 2, 0, 0);
    endtask

    task automatic test_random_frames();
        run_random("rand", 5, 30, 1);
    endtask

`ifdef RLE_AUDIO_EN
    task automatic test_audio();
        stim_q.delete();
        for (int i = 0; i < 4; i++) push_px(6'h00, i == 3, i == 3, 8'hA5);
        exp_q = '{16'h0100, 16'h00A5, 16'h0000};
        got_q.delete();
        drive_pixels(0);
        wait_words();
        checks++;
        if (drv_timeout || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL audio_count got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), drv_timeout);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL audio_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_runs();
        test_max_run();
        test_eof();
        test_backpressure();
        test_reset_midrun();
`ifdef RLE_AUDIO_EN
        test_audio();
`endif
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
